// File: rtl/prog_loader_mem_if.sv
// Fetch and program-load bus between the CPU/loader side (master) and the program memory (slave).
interface prog_loader_mem_if;
  logic [3:0] address;
  logic [7:0] instr;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       run;
  logic       cpu_n_reset;
  logic       load_err;

  modport master (
    output address, load_start, load_valid, load_data, run,
    input  instr, load_ready, cpu_n_reset, load_err
  );

  modport slave (
    input  address, load_start, load_valid, load_data, run,
    output instr, load_ready, cpu_n_reset, load_err
  );
endinterface

// File: rtl/prog_loader_mem.sv
// 16x8 TD4 program memory with a sequential byte-stream loader that holds the CPU in reset until loaded.
// Optional trailing checksum byte: define PROG_LOADER_MEM_CHECKSUM_EN.
module prog_loader_mem (
  input logic              clk,
  input logic              n_reset,
  prog_loader_mem_if.slave bus
);
  localparam int DEPTH = 16;

  localparam logic [1:0] HALT = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
`ifdef PROG_LOADER_MEM_CHECKSUM_EN
  localparam logic [1:0] CHK  = 2'd3;
`endif

  logic [1:0]            state, state_nxt;
  logic [3:0]            wptr;
  logic [DEPTH-1:0][7:0] mem;
  logic                  ready;
  logic                  accept;
  logic                  wr_en;
  logic                  cpu_n_reset;

  // Fetch is a plain mux over the flops, so a same-cycle write shows up only after the edge.
  assign bus.instr = mem[bus.address];

`ifdef PROG_LOADER_MEM_CHECKSUM_EN
  logic [7:0] sum;
  logic       load_err;
  assign ready = (state == LOAD) || (state == CHK);
`else
  assign ready = (state == LOAD);
`endif

  // A byte presented alongside load_start is dropped; the restart takes priority.
  assign accept = bus.load_valid & ready & ~bus.load_start;
  assign wr_en  = accept & (state == LOAD);

  always_comb begin
    state_nxt = state;
    case (state)
      HALT: begin
        if (bus.load_start)   state_nxt = LOAD;
        else if (bus.run)     state_nxt = RUN;
      end
      RUN: begin
        if (bus.load_start)   state_nxt = LOAD;
      end
      LOAD: begin
        if (bus.load_start)   state_nxt = LOAD;
`ifdef PROG_LOADER_MEM_CHECKSUM_EN
        else if (accept && wptr == 4'hF) state_nxt = CHK;
`else
        else if (accept && wptr == 4'hF) state_nxt = RUN;
`endif
      end
`ifdef PROG_LOADER_MEM_CHECKSUM_EN
      CHK: begin
        if (bus.load_start)   state_nxt = LOAD;
        else if (accept)      state_nxt = (bus.load_data == sum) ? RUN : HALT;
      end
`endif
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= HALT;
      wptr        <= '0;
      mem         <= '0;
      cpu_n_reset <= 1'b0;
    end else begin
      state       <= state_nxt;
      cpu_n_reset <= (state_nxt == RUN);
      if (bus.load_start) begin
        wptr <= '0;
      end else if (wr_en) begin
        mem[wptr] <= bus.load_data;
        wptr      <= wptr + 4'd1;
      end
    end
  end

`ifdef PROG_LOADER_MEM_CHECKSUM_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sum      <= '0;
      load_err <= 1'b0;
    end else begin
      if (bus.load_start) begin
        sum      <= '0;
        load_err <= 1'b0;
      end else if (wr_en) begin
        sum <= sum + bus.load_data;
      end else if (accept && state == CHK && bus.load_data != sum) begin
        load_err <= 1'b1;
      end
    end
  end
  assign bus.load_err = load_err;
`else
  assign bus.load_err = 1'b0;
`endif

  assign bus.load_ready  = ready;
  assign bus.cpu_n_reset = cpu_n_reset;
endmodule
